// File: rtl/mc_controller_if.sv
// mc_controller_if: bundle between the multicycle control FSM and the datapath.
//   opcode/funct : instruction register fields (IR[31:26], IR[5:0])
//   zero         : ALU zero flag
//   PCEn..ZeroExt: datapath enables and mux selects
//   ALUoperation : 3-bit ALU code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
// master = controller (drives controls), slave = datapath (drives IR fields, zero).
interface mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ZeroExt;
  logic [1:0] PCSrc;
  logic [2:0] ALUoperation;

  modport master (
    input  opcode, funct, zero,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ZeroExt, PCSrc, ALUoperation
  );

  modport slave (
    output opcode, funct, zero,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ZeroExt, PCSrc, ALUoperation
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS main control FSM (Moore).
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, returns the FSM to FETCH
//   bus   : mc_controller_if.master -- IR fields and zero in, datapath controls out
//   state : current 4-bit state (debug)
// Build option: define MC_CTRL_IMM_EN to add addi/andi/slti via IMM_EX/IMM_WB;
// without it those opcodes are treated as illegal and ZeroExt stays 0.
module mc_controller (
  input  logic                    clk,
  input  logic                    rst,
  mc_controller_if.master         bus,
  output logic [3:0]              state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] RTYPE_EX = 4'd6;
  localparam logic [3:0] RTYPE_WB = 4'd7;
  localparam logic [3:0] BEQ      = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
`ifdef MC_CTRL_IMM_EN
  localparam logic [3:0] IMM_EX   = 4'd10;
  localparam logic [3:0] IMM_WB   = 4'd11;
`endif

  logic [3:0] state_q, state_d;
  logic       pcwrite, pcwritecond;
  logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, zeroext;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = FETCH;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    zeroext     = 1'b0;
    pcsrc       = 2'b00;
    aluop       = 3'b010;
    case (state_q)
      FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (bus.opcode)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = RTYPE_EX;
          6'b000100:            state_d = BEQ;
          6'b000010:            state_d = JUMP;
`ifdef MC_CTRL_IMM_EN
          6'b001000, 6'b001100, 6'b001010: state_d = IMM_EX;
`endif
          default:              state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (bus.opcode == 6'b101011) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      RTYPE_EX: begin
        alusrca = 1'b1;
        state_d = RTYPE_WB;
        case (bus.funct)
          6'b100100: aluop = 3'b000;
          6'b100101: aluop = 3'b001;
          6'b100000: aluop = 3'b010;
          6'b100010: aluop = 3'b110;
          6'b101010: aluop = 3'b111;
          default:   state_d = FETCH;  // illegal funct: abandon, no writeback
        endcase
      end
      RTYPE_WB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQ: begin
        alusrca     = 1'b1;
        aluop       = 3'b110;
        pcwritecond = 1'b1;
        pcsrc       = 2'b01;
      end
      JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
`ifdef MC_CTRL_IMM_EN
      IMM_EX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = IMM_WB;
        case (bus.opcode)
          6'b001100: begin
            aluop   = 3'b000;
            zeroext = 1'b1;
          end
          6'b001010: aluop = 3'b111;
          default:   aluop = 3'b010;
        endcase
      end
      IMM_WB: begin
        regwrite = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  assign state            = state_q;
  assign bus.PCEn         = pcwrite | (pcwritecond & bus.zero);
  assign bus.IorD         = iord;
  assign bus.MemRead      = memread;
  assign bus.MemWrite     = memwrite;
  assign bus.IRWrite      = irwrite;
  assign bus.RegDst       = regdst;
  assign bus.MemtoReg     = memtoreg;
  assign bus.RegWrite     = regwrite;
  assign bus.ALUSrcA      = alusrca;
  assign bus.ALUSrcB      = alusrcb;
  assign bus.ZeroExt      = zeroext;
  assign bus.PCSrc        = pcsrc;
  assign bus.ALUoperation = aluop;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller.
module tb_mc_controller;
  logic       clk;
  logic       rst;
  logic [3:0] state;
  int         n_checks;
  int         n_fails;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag);
    check({tag, " state"},   32'(state), 32'd0);
    check({tag, " MemRead"}, 32'(bus.MemRead), 32'd1);
    check({tag, " IRWrite"}, 32'(bus.IRWrite), 32'd1);
    check({tag, " PCEn"},    32'(bus.PCEn), 32'd1);
    check({tag, " ALUop"},   32'(bus.ALUoperation), 32'd2);
    check({tag, " ALUSrcB"}, 32'(bus.ALUSrcB), 32'd1);
    check({tag, " PCSrc"},   32'(bus.PCSrc), 32'd0);
    check({tag, " MemWrite"},32'(bus.MemWrite), 32'd0);
    check({tag, " RegWrite"},32'(bus.RegWrite), 32'd0);
  endtask

  logic [5:0] rfunct [5] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
  logic [2:0] raluop [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b1;
    bus.opcode = 6'b111111;
    bus.funct  = 6'b000000;
    bus.zero   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_fetch("reset held");
    rst = 1'b0;
    expect_fetch("reset release");

    // lw: 0,1,2,3,4,0
    bus.opcode = 6'b100011;
    tick; check("lw s1", 32'(state), 32'd1);
    check("lw decode ALUSrcB", 32'(bus.ALUSrcB), 32'd3);
    check("lw decode PCEn", 32'(bus.PCEn), 32'd0);
    tick; check("lw s2", 32'(state), 32'd2);
    check("lw memadr ALUSrcA", 32'(bus.ALUSrcA), 32'd1);
    check("lw memadr ALUSrcB", 32'(bus.ALUSrcB), 32'd2);
    tick; check("lw s3", 32'(state), 32'd3);
    check("lw memrd MemRead", 32'(bus.MemRead), 32'd1);
    check("lw memrd IorD", 32'(bus.IorD), 32'd1);
    tick; check("lw s4", 32'(state), 32'd4);
    check("lw memwb RegWrite", 32'(bus.RegWrite), 32'd1);
    check("lw memwb MemtoReg", 32'(bus.MemtoReg), 32'd1);
    check("lw memwb RegDst", 32'(bus.RegDst), 32'd0);
    tick; expect_fetch("lw end");

    // sw: 0,1,2,5,0
    bus.opcode = 6'b101011;
    tick; check("sw s1", 32'(state), 32'd1);
    tick; check("sw s2", 32'(state), 32'd2);
    tick; check("sw s5", 32'(state), 32'd5);
    check("sw MemWrite", 32'(bus.MemWrite), 32'd1);
    check("sw IorD", 32'(bus.IorD), 32'd1);
    check("sw RegWrite", 32'(bus.RegWrite), 32'd0);
    tick; expect_fetch("sw end");

    // reset asserted mid-MEMWR
    tick; tick; tick;
    check("rst pre state", 32'(state), 32'd5);
    check("rst pre MemWrite", 32'(bus.MemWrite), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst async MemWrite", 32'(bus.MemWrite), 32'd0);
    check("rst async state", 32'(state), 32'd0);
    tick; expect_fetch("rst held edge");
    rst = 1'b0;
    expect_fetch("rst released");

    // R-type sweep
    bus.opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      bus.funct = rfunct[i];
      tick; check("rtype s1", 32'(state), 32'd1);
      tick; check("rtype s6", 32'(state), 32'd6);
      check($sformatf("rtype aluop f=%b", rfunct[i]), 32'(bus.ALUoperation), 32'(raluop[i]));
      check("rtype ex ALUSrcA", 32'(bus.ALUSrcA), 32'd1);
      check("rtype ex ALUSrcB", 32'(bus.ALUSrcB), 32'd0);
      check("rtype ex RegWrite", 32'(bus.RegWrite), 32'd0);
      tick; check("rtype s7", 32'(state), 32'd7);
      check("rtype wb RegWrite", 32'(bus.RegWrite), 32'd1);
      check("rtype wb RegDst", 32'(bus.RegDst), 32'd1);
      check("rtype wb MemtoReg", 32'(bus.MemtoReg), 32'd0);
      tick; expect_fetch("rtype end");
    end

    // illegal funct
    bus.funct = 6'b000111;
    tick; check("badfunct s1", 32'(state), 32'd1);
    tick; check("badfunct s6", 32'(state), 32'd6);
    check("badfunct aluop", 32'(bus.ALUoperation), 32'd2);
    check("badfunct RegWrite", 32'(bus.RegWrite), 32'd0);
    tick; expect_fetch("badfunct end");

    // beq taken, then zero drops combinationally
    bus.opcode = 6'b000100;
    bus.zero   = 1'b1;
    tick; check("beq s1", 32'(state), 32'd1);
    tick; check("beq s8", 32'(state), 32'd8);
    check("beq taken PCEn", 32'(bus.PCEn), 32'd1);
    check("beq PCSrc", 32'(bus.PCSrc), 32'd1);
    check("beq aluop", 32'(bus.ALUoperation), 32'd6);
    bus.zero = 1'b0;
    #1;
    check("beq zero drop PCEn", 32'(bus.PCEn), 32'd0);
    tick; expect_fetch("beq end");
    // beq not taken
    tick; check("beq2 s1", 32'(state), 32'd1);
    tick; check("beq2 s8", 32'(state), 32'd8);
    check("beq nt PCEn", 32'(bus.PCEn), 32'd0);
    check("beq nt aluop", 32'(bus.ALUoperation), 32'd6);
    tick; expect_fetch("beq2 end");

    // jump
    bus.opcode = 6'b000010;
    tick; check("j s1", 32'(state), 32'd1);
    tick; check("j s9", 32'(state), 32'd9);
    check("j PCEn", 32'(bus.PCEn), 32'd1);
    check("j PCSrc", 32'(bus.PCSrc), 32'd2);
    tick; expect_fetch("j end");

    // illegal opcode
    bus.opcode = 6'b111111;
    tick; check("ill s1", 32'(state), 32'd1);
    check("ill RegWrite", 32'(bus.RegWrite), 32'd0);
    check("ill MemWrite", 32'(bus.MemWrite), 32'd0);
    check("ill PCEn", 32'(bus.PCEn), 32'd0);
    tick; expect_fetch("ill end");

    // andi
    bus.opcode = 6'b001100;
    tick; check("andi s1", 32'(state), 32'd1);
`ifdef MC_CTRL_IMM_EN
    tick; check("andi s10", 32'(state), 32'd10);
    check("andi aluop", 32'(bus.ALUoperation), 32'd0);
    check("andi ZeroExt", 32'(bus.ZeroExt), 32'd1);
    check("andi ALUSrcB", 32'(bus.ALUSrcB), 32'd2);
    tick; check("andi s11", 32'(state), 32'd11);
    check("andi RegWrite", 32'(bus.RegWrite), 32'd1);
    check("andi RegDst", 32'(bus.RegDst), 32'd0);
    check("andi MemtoReg", 32'(bus.MemtoReg), 32'd0);
`else
    check("andi noimm RegWrite", 32'(bus.RegWrite), 32'd0);
    check("andi noimm ZeroExt", 32'(bus.ZeroExt), 32'd0);
`endif
    tick; expect_fetch("andi end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS main control FSM. Drives the datapath control lines and the 3-bit ALUoperation code that the ALU consumes.
- It is the producer end of the ALU operation interface: it decodes opcode and funct from the instruction register into ALU codes.
- Sits between the instruction register and the datapath muxes, register file and memory enables.

Parameters:
- none (encodings fixed; see Behaviour)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], stable from DECODE until return to FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in the BEQ state
- PCEn  out  1  PC load = PCWrite | (PCWriteCond & zero)
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = extended imm, 11 = sign-extended imm<<2
- ZeroExt  out  1  1 = zero-extend imm (andi only), else sign-extend
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUoperation  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- state  out  4  current state (debug)

Behaviour:
- Moore FSM, 4-bit state register, asynchronous reset to FETCH.
- All outputs are combinational from the state. Exceptions: PCEn also uses zero; ALUoperation in RTYPE_EX also uses funct.
- Defaults in every state: all enables 0, muxes 0, ALUoperation=010.
- Reset values: outputs equal the FETCH decode, held while rst=1.
- Reset asserted mid-instruction aborts the instruction. No write issues after the reset edge. FETCH is the first state after release.
- States and outputs:
  - FETCH (0): MemRead, IRWrite, ALUSrcB=01, ALUoperation=010, PCWrite (PCEn=1), PCSrc=00. Next: DECODE.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUoperation=010 (branch target precompute). Next by opcode:
    - 100011 / 101011 → MEMADR
    - 000000 → RTYPE_EX
    - 000100 → BEQ
    - 000010 → JUMP
    - immediate ops → IMM_EX (see Optional Feature)
    - any other opcode → FETCH (treated as NOP; no write occurs)
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUoperation=010. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD (3): MemRead, IorD=1. Next: MEMWB.
  - MEMWB (4): RegWrite, MemtoReg=1, RegDst=0. Next: FETCH.
  - MEMWR (5): MemWrite, IorD=1. Next: FETCH.
  - RTYPE_EX (6): ALUSrcA=1, ALUSrcB=00, ALUoperation from funct:
    - 100100 → 000
    - 100101 → 001
    - 100000 → 010
    - 100010 → 110
    - 101010 → 111
    - Legal funct → RTYPE_WB. Illegal funct → ALUoperation=010, next FETCH, no RegWrite.
  - RTYPE_WB (7): RegWrite, RegDst=1, MemtoReg=0. Next: FETCH.
  - BEQ (8): ALUSrcA=1, ALUSrcB=00, ALUoperation=110, PCWriteCond, PCSrc=01. PCEn=zero. Next: FETCH.
  - JUMP (9): PCWrite, PCSrc=10. Next: FETCH.
  - IMM_EX (10) / IMM_WB (11): see Optional Feature.
- Cycle counts, FETCH inclusive: lw 5; sw 4; R-type 4; beq 3; j 3; imm 4; illegal 2.
- Unused state encodings 12–15 → next FETCH, outputs at defaults.
- PCEn never asserts outside FETCH, BEQ and JUMP.

Optional Feature:
- Macro: MC_CTRL_IMM_EN.
- Defined:
  - Opcodes 001000 addi, 001100 andi and 001010 slti go DECODE → IMM_EX → IMM_WB → FETCH.
  - IMM_EX: ALUSrcA=1, ALUSrcB=10. ALUoperation is 010 / 000 / 111 respectively. ZeroExt=1 for andi only.
  - IMM_WB: RegWrite, RegDst=0, MemtoReg=0.
- Undefined:
  - Those opcodes take the illegal-opcode path (DECODE → FETCH, no write).
  - States 10–11 are unreachable and behave as unused encodings.
  - ZeroExt is tied to 0.

Test Plan:
- Reset: assert rst mid-MEMWR with MemWrite high → MemWrite drops immediately (asynchronous); after release state=0 and outputs match FETCH (MemRead=1, IRWrite=1, PCEn=1, ALUoperation=010).
- R-type sweep: opcode=000000 with funct 100100/100101/100000/100010/101010 → ALUoperation in RTYPE_EX is 000/001/010/110/111, and RegWrite=1, RegDst=1 in the next cycle. funct=000111 → FETCH after RTYPE_EX with no RegWrite pulse.
- lw then sw: opcode 100011 → state sequence 0,1,2,3,4,0 with MemtoReg=1 and RegWrite in state 4; opcode 101011 → 0,1,2,5,0 with MemWrite=1 and IorD=1 in state 5.
- beq: opcode 000100 with zero=1 → PCEn=1, PCSrc=01 in state 8; repeat with zero=0 → PCEn=0; ALUoperation=110 in both.
- j and illegal opcode: 000010 → state 9 with PCEn=1, PCSrc=10. Opcode 111111 → 0,1,0 with no RegWrite, MemWrite or PCEn outside FETCH.
- With MC_CTRL_IMM_EN: andi 001100 → state 10 with ALUoperation=000 and ZeroExt=1, then state 11 with RegWrite=1. Without the macro, the same opcode → 0,1,0 with no RegWrite.
